serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Multi-cycle digit-serial subtractor: sub_out = in1 - in2 (32-bit, modulo 2^32).
//   Inverse operation to the cache datapath's combinational 32-bit adder.
//   Used where address/offset differences are needed but timing or area rules out a full-width
//   combinational borrow chain (e.g. tag-distance and index-delta computation in the cache controller).
//   Processes DIGIT bits per clock and handshakes with start/busy/done.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   DIGIT  4   bits subtracted per cycle; must divide WIDTH (NDIG = WIDTH/DIGIT, default 8)
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      request; sampled only when not busy
//   in1         in   WIDTH  minuend, captured on accepted start
//   in2         in   WIDTH  subtrahend, captured on accepted start
//   busy        out  1      high while digits are being processed
//   done        out  1      one-cycle pulse: result valid
//   sub_out     out  WIDTH  in1 - in2; held until next accepted start completes
//   borrow_out  out  1      1 when in1 < in2 unsigned (final borrow)
//   zero        out  1      1 when sub_out == 0
//   ovf         out  1      signed overflow (present only with SERIAL_SUB_OVF_EN)
// BEHAVIOUR
//   Reset (async, any time, incl. mid-operation): state=IDLE; busy, done, sub_out, borrow_out, zero, ovf = 0;
//     the internal digit counter and borrow are cleared; captured operands are discarded.
//   FSM states:
//     IDLE --start--> RUN
//     RUN (NDIG cycles) --> DONE
//     DONE --start--> RUN, else --> IDLE
//   Accept: start=1 at an edge while state is IDLE or DONE.
//     Operands are latched, the borrow is cleared, and the digit counter is set to 0.
//     busy=1 from that edge.
//   RUN: each edge computes {b, d} = op1[k] - op2[k] - borrow on digit k (LSB digit first).
//     d is written to the result shift register; the digit counter k is incremented.
//   Latency: accept at edge E. Digits are processed at edges E+1..E+NDIG.
//     At edge E+NDIG: sub_out, borrow_out and zero update; busy=0; done=1 for exactly one cycle.
//   sub_out, borrow_out and zero change only at completion; they are never partial values.
//   start while busy: ignored; it is not queued and does not disturb the operation.
//   Back-to-back: start during the done cycle is accepted. done then falls and busy rises on that same edge.
//   Width rules: the result wraps modulo 2^WIDTH.
//     borrow_out = carry-out of the MSB digit (borrow set means in1 < in2 unsigned).
//   zero is derived from the final full-width result, not from the last digit.
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined:
//     ovf port exists; ovf = (in1[MSB] != in2[MSB]) && (sub_out[MSB] != in1[MSB]).
//     It updates together with sub_out and resets to 0.
//   SERIAL_SUB_OVF_EN undefined:
//     ovf port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//   Shared package holds:
//     - the FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//     - the defaults WIDTH=32, DIGIT=4, and derived NDIG
//     - the counter width = clog2(NDIG)
//   One sub-module: sub_digit, a combinational DIGIT-bit borrow-chain cell.
//     Inputs: a, b, bin. Outputs: d, bout.
//     It is instantiated once and reused every cycle.
//   Top level contains the FSM, the digit counter, the operand shift registers and the result/flag registers.
// TESTING
//   1. in1=10, in2=3, start pulse -> done exactly 8 cycles after accept;
//      sub_out=7, borrow_out=0, zero=0.
//   2. in1=0, in2=1 -> sub_out=32'hFFFF_FFFF, borrow_out=1, zero=0.
//   3. in1=in2=32'h1234_5678 -> sub_out=0, zero=1, borrow_out=0.
//   4. start held high through RUN with in1/in2 changed mid-operation -> result uses the first operands.
//      A new operation starts only on the done-cycle edge; next done follows 8 cycles later.
//   5. rst_n low at cycle 4 of RUN -> busy=0, done=0, outputs 0 immediately; no done pulse follows.
//      A fresh start afterwards computes correctly.
//   6. (SERIAL_SUB_OVF_EN) in1=32'h8000_0000, in2=1 -> sub_out=32'h7FFF_FFFF, ovf=1, borrow_out=0.
//      in1=5, in2=3 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM encoding and default sizing.
package serial_subtractor_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DIGIT = 4;
  localparam int unsigned DEF_NDIG  = DEF_WIDTH / DEF_DIGIT;
  localparam int unsigned DEF_CNT_W = (DEF_NDIG > 1) ? $clog2(DEF_NDIG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit borrow-chain cell: {bout, d} = a - b - bin.
import serial_subtractor_pkg::*;

module sub_digit #(
  parameter int unsigned DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] diff;

  // Extra MSB of the (DIGIT+1)-bit difference is the outgoing borrow
  assign diff = {1'b0, a} - {1'b0, b} - (DIGIT+1)'(bin);
  assign d    = diff[DIGIT-1:0];
  assign bout = diff[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle digit-serial subtractor, sub_out = in1 - in2, DIGIT bits per clock.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
import serial_subtractor_pkg::*;

module serial_subtractor #(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sub_out,
  output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             zero
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               brw;
  logic [WIDTH-1:0]   op1, op2, res;
  logic [WIDTH-1:0]   res_nxt;
  logic [DIGIT-1:0]   dig;
  logic               dig_bout;
  logic               accept, last;
`ifdef SERIAL_SUB_OVF_EN
  logic               s1, s2;
`endif

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (op1[DIGIT-1:0]),
    .b    (op2[DIGIT-1:0]),
    .bin  (brw),
    .d    (dig),
    .bout (dig_bout)
  );

  // Result fills from the top so the LSB digit lands at bit 0 after NDIG shifts
  assign res_nxt = {dig, res[WIDTH-1:DIGIT]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt == CNT_W'(NDIG - 1)) begin
          last      = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags follow the next state so they are registered with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_RUN);
      done <= (state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1        <= '0;
      op2        <= '0;
      res        <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      sub_out    <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      s1         <= 1'b0;
      s2         <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else if (accept) begin
      op1 <= in1;
      op2 <= in2;
      cnt <= '0;
      brw <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      s1  <= in1[WIDTH-1];
      s2  <= in2[WIDTH-1];
`endif
    end else if (state == ST_RUN) begin
      op1 <= op1 >> DIGIT;
      op2 <= op2 >> DIGIT;
      res <= res_nxt;
      brw <= dig_bout;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        sub_out    <= res_nxt;
        borrow_out <= dig_bout;
        zero       <= (res_nxt == '0);
`ifdef SERIAL_SUB_OVF_EN
        ovf        <= (s1 != s2) && (res_nxt[WIDTH-1] != s1);
`endif
      end
    end
  end

endmodule
